// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter-side bundle of the UART TX queue; master drives the inputs, slave is the queue.
interface uart_tx_queue_if #(
  parameter int ADDR_W = 4
);
  logic              i_wr_en;
  logic [7:0]        i_wr_data;
  logic              i_tx_busy;
  logic              i_clr_ovf;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;

  modport master (
    output i_wr_en, i_wr_data, i_tx_busy, i_clr_ovf,
    input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_tx_busy, i_clr_ovf,
    output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter via start pulse / busy handshake; start is 2 cycles after a write to an idle empty queue.
// Backpressure: writes into a full queue are dropped (sticky overflow) unless a pop happens on the same edge.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_queue_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ovf_q, ovf_d;

  logic full, empty, pop, wr_acc, wr_drop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = (state_q == IDLE) && !empty && !bus.i_tx_busy;
  // A full queue still takes a write when the same edge frees a slot.
  assign wr_acc  = bus.i_wr_en && (!full || pop);
  assign wr_drop = bus.i_wr_en && full && !pop;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    ovf_d     = ovf_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q] = bus.i_wr_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
    end
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (bus.i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = LAUNCH;
          tx_start_d = 1'b1;
        end
      end
      LAUNCH: begin
        tmo_d   = TMO_W'(BUSY_TIMEOUT);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          // No busy within the window: the byte is abandoned, not retried.
          tmo_d = tmo_q - TMO_W'(1);
          if (tmo_q == TMO_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: queue/launch-window model checked every cycle plus directed literal checks.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: byte queue, expected output registers, and the launcher's busy-sampling windows in edge numbers.
  logic [7:0] m_q[$];
  logic       m_start = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  int         lmode = 0;  // 0 ready, 1 waiting for busy to rise, 2 waiting for busy to fall
  int         win_lo = 0;
  int         win_hi = 0;
  int         cyc = 0;
  logic [7:0] tx_log[$];

  int hold_busy = 0;
  int busy_len = 0;
  int rcnt = 0;

  always @(posedge clk) begin
    if (reset) begin : mdl
      logic b, pop, acc, drop;
      cyc++;
      b    = bus.i_tx_busy;
      pop  = (lmode == 0) && (m_q.size() > 0) && !b;
      if (lmode == 1 && cyc >= win_lo) begin
        if (b) lmode = 2;
        else if (cyc == win_hi) lmode = 0;
      end else if (lmode == 2) begin
        if (!b) lmode = 0;
      end
      acc  = bus.i_wr_en && ((m_q.size() < DEPTH) || pop);
      drop = bus.i_wr_en && (m_q.size() == DEPTH) && !pop;
      if (pop) begin
        m_data = m_q.pop_front();
        lmode  = 1;
        win_lo = cyc + 2;
        win_hi = cyc + 1 + T;
      end
      if (acc) m_q.push_back(bus.i_wr_data);
      if (drop) m_ovf = 1'b1;
      else if (bus.i_clr_ovf) m_ovf = 1'b0;
      m_start = pop;
    end
  end

  always @(negedge reset) begin
    m_q.delete();
    m_start = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
    lmode   = 0;
  end

  always @(negedge clk) begin
    chk("start", int'(bus.o_tx_start), int'(m_start));
    chk("data", int'(bus.o_tx_data), int'(m_data));
    chk("count", int'(bus.o_count), m_q.size());
    chk("full", int'(bus.o_full), int'(m_q.size() == DEPTH));
    chk("empty", int'(bus.o_empty), int'(m_q.size() == 0));
    chk("ovf", int'(bus.o_overflow), int'(m_ovf));
    if (reset && bus.o_tx_start) tx_log.push_back(bus.o_tx_data);
  end

  // Transmitter stand-in: busy for busy_len cycles after each start, or forced high by hold_busy.
  always @(negedge clk) begin
    #2;
    if (bus.o_tx_start && busy_len > 0) rcnt = busy_len;
    bus.i_tx_busy = (hold_busy != 0) || (rcnt > 0);
    if (rcnt > 0) rcnt--;
  end

  task automatic wr(input logic [7:0] b);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = b;
    @(negedge clk);
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(nm, int'(tx_log.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [7:0] seq[40];
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_clr_ovf = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", int'(bus.o_empty), 1);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_start", int'(bus.o_tx_start), 0);
    #3 reset = 1'b1;
    @(negedge clk);

    // Single byte: start pulse in the cycle after the pop edge.
    busy_len = 10;
    wr(8'hA5);
    chk("t1_no_start_yet", int'(bus.o_tx_start), 0);
    chk("t1_count_1", int'(bus.o_count), 1);
    @(negedge clk);
    chk("t1_start", int'(bus.o_tx_start), 1);
    chk("t1_data", int'(bus.o_tx_data), 8'hA5);
    chk("t1_count_0", int'(bus.o_count), 0);
    @(negedge clk);
    chk("t1_pulse_1cyc", int'(bus.o_tx_start), 0);
    repeat (16) @(negedge clk);
    chk("t1_empty", int'(bus.o_empty), 1);

    // Burst to full, then one dropped write.
    hold_busy = 1;
    busy_len = 0;
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("t2_full", int'(bus.o_full), 1);
    chk("t2_count16", int'(bus.o_count), 16);
    wr(8'hFF);
    chk("t2_ovf", int'(bus.o_overflow), 1);
    chk("t2_count_stays", int'(bus.o_count), 16);
    bus.i_clr_ovf = 1'b1;
    @(negedge clk);
    bus.i_clr_ovf = 1'b0;
    chk("t2_ovf_clr", int'(bus.o_overflow), 0);
    busy_len = 5;
    hold_busy = 0;
    wait_log(17, 400, "t2_drain");
    repeat (20) @(negedge clk);
    chk("t2_log_size", tx_log.size(), 17);
    for (int i = 0; i < 16; i++)
      if (tx_log.size() > i + 1) chk("t2_order", int'(tx_log[i+1]), i);

    // Full queue with a write on the same edge as a pop.
    hold_busy = 1;
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    chk("t3_full", int'(bus.o_full), 1);
    hold_busy = 0;
    wr(8'h55);
    chk("t3_count16", int'(bus.o_count), 16);
    chk("t3_no_ovf", int'(bus.o_overflow), 0);
    chk("t3_start", int'(bus.o_tx_start), 1);
    chk("t3_first", int'(bus.o_tx_data), 8'h80);
    wait_log(34, 400, "t3_drain");
    if (tx_log.size() >= 34) chk("t3_last55", int'(tx_log[33]), 8'h55);

    // Busy never rises: the launcher gives up after the timeout window.
    repeat (10) @(negedge clk);
    busy_len = 0;
    wr(8'h3C);
    wr(8'h3D);
    chk("t4_start1", int'(bus.o_tx_start), 1);
    chk("t4_data1", int'(bus.o_tx_data), 8'h3C);
    @(negedge clk);
    busy_len = 4;
    n = 1;
    while (!bus.o_tx_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_gap", n, T + 2);
    chk("t4_data2", int'(bus.o_tx_data), 8'h3D);
    repeat (12) @(negedge clk);

    // Streaming 40 bytes through the 16-deep ring with a 5-cycle frame.
    busy_len = 5;
    base = tx_log.size();
    for (int i = 0; i < 40; i++) seq[i] = 8'((i * 37 + 11) & 8'hFF);
    n = 0;
    for (int g = 0; g < 2000 && n < 40; g++) begin
      if (!bus.o_full) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = seq[n];
        n++;
      end else begin
        bus.i_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_wr_en = 1'b0;
    wait_log(base + 40, 800, "t5_drain");
    for (int j = 0; j < 40; j++)
      if (tx_log.size() > base + j) chk("t5_order", int'(tx_log[base+j]), int'(seq[j]));
    chk("t5_no_ovf", int'(bus.o_overflow), 0);

    // Asynchronous reset while a frame is in flight and 3 bytes wait.
    repeat (10) @(negedge clk);
    busy_len = 30;
    wr(8'h61);
    wr(8'h62);
    wr(8'h63);
    wr(8'h64);
    repeat (4) @(negedge clk);
    chk("t6_count3", int'(bus.o_count), 3);
    chk("t6_busy_data", int'(bus.o_tx_data), 8'h61);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_start", int'(bus.o_tx_start), 0);
    chk("t6_rst_data", int'(bus.o_tx_data), 0);
    chk("t6_rst_full", int'(bus.o_full), 0);
    chk("t6_rst_empty", int'(bus.o_empty), 1);
    chk("t6_rst_count", int'(bus.o_count), 0);
    chk("t6_rst_ovf", int'(bus.o_overflow), 0);
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    base = tx_log.size();
    repeat (40) @(negedge clk);
    chk("t6_no_start", tx_log.size() - base, 0);
    busy_len = 3;
    wr(8'h77);
    @(negedge clk);
    chk("t6_new_start", int'(bus.o_tx_start), 1);
    chk("t6_new_data", int'(bus.o_tx_data), 8'h77);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
